// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the mem_intf bus (the `mem` modport end).
// Holds 32 x 8 bits of storage with synchronous write and a registered read
// pipeline of READ_LAT stages. It also keeps saturating access counters, a
// sticky read/write collision flag and a flag that marks reads of words not
// written since reset.
//
// Parameters:
//   READ_LAT  read latency in posedges, 1..4. The sampling posedge counts as 1.
//   CNT_W     width of rd_cnt / wr_cnt.
//
// Ports:
//   clk        bus clock; everything is sampled on the posedge
//   rst_n      asynchronous active-low reset
//   data_in    write data
//   addr_rn    word address for reads and writes, 0..31
//   read       read request
//   write      write request
//   data_out   read data; holds the last read result
//   rd_valid   one-cycle pulse when data_out updates
//   uninit_rd  one-cycle pulse with rd_valid when the word was never written
//   rw_err     sticky; set when read and write are both high
//   clr_err    synchronous clear of rw_err
//   rd_cnt     accepted reads, saturating
//   wr_cnt     accepted writes, saturating
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic [4:0]       addr_rn,
    input  logic             read,
    input  logic             write,
    output logic [7:0]       data_out,
    output logic             rd_valid,
    output logic             uninit_rd,
    output logic             rw_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int unsigned DEPTH = 32;

    // Storage and per-word "written since reset" flags
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;

    // Read pipeline; the last stage drives the outputs directly
    logic [READ_LAT-1:0] pipe_vld_q;
    logic [READ_LAT-1:0] pipe_vld_d;
    logic [READ_LAT-1:0] pipe_uninit_q;
    logic [READ_LAT-1:0] pipe_uninit_d;
    logic [7:0]          pipe_data_q [READ_LAT];
    logic [7:0]          pipe_data_d [READ_LAT];

    logic             rw_err_q;
    logic             rw_err_d;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d;

    // Request decode: a collision suppresses both the read and the write
    logic rd_acc;
    logic wr_acc;
    logic collide;

    always_comb begin
        rd_acc  = read & ~write;
        wr_acc  = write & ~read;
        collide = read & write;
    end

    // Storage update
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        if (wr_acc) begin
            mem_d[addr_rn]     = data_in;
            written_d[addr_rn] = 1'b1;
        end
    end

    // Read pipeline. Stage 0 captures the word at the sampling posedge, so a
    // write in a later cycle to the same address cannot alter a read already
    // in flight. Data registers only load alongside a valid token, which
    // makes data_out hold its last result between reads.
    always_comb begin
        pipe_vld_d[0]    = rd_acc;
        pipe_uninit_d[0] = rd_acc & ~written_q[addr_rn];
        pipe_data_d[0]   = rd_acc ? mem_q[addr_rn] : pipe_data_q[0];
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            pipe_vld_d[i]    = pipe_vld_q[i-1];
            pipe_uninit_d[i] = pipe_uninit_q[i-1];
            pipe_data_d[i]   = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
        end
    end

    // Error flag: a collision in the same cycle as clr_err keeps the flag set
    always_comb begin
        rw_err_d = rw_err_q;
        if (collide) begin
            rw_err_d = 1'b1;
        end else if (clr_err) begin
            rw_err_d = 1'b0;
        end
    end

    // Saturating access counters
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_acc && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (wr_acc && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q     <= '0;
            pipe_vld_q    <= '0;
            pipe_uninit_q <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
            rw_err_q <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            written_q     <= written_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_uninit_q <= pipe_uninit_d;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            rw_err_q <= rw_err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        data_out  = pipe_data_q[READ_LAT-1];
        rd_valid  = pipe_vld_q[READ_LAT-1];
        uninit_rd = pipe_uninit_q[READ_LAT-1];
        rw_err    = rw_err_q;
        rd_cnt    = rd_cnt_q;
        wr_cnt    = wr_cnt_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. Four instances share the bus inputs:
//   u_l1 : READ_LAT=1, CNT_W=16
//   u_l2 : READ_LAT=2, CNT_W=16
//   u_l3 : READ_LAT=3, CNT_W=16
//   u_c4 : READ_LAT=1, CNT_W=4
// Inputs change on the negedge; outputs are sampled on the negedge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [4:0] addr_rn;
    logic       read;
    logic       write;
    logic       clr_err;

    always #5 clk = ~clk;

    logic [7:0]  d1, d2, d3, d4;
    logic        v1, v2, v3, v4;
    logic        un1, un2, un3, un4;
    logic        e1, e2, e3, e4;
    logic [15:0] rc1, rc2, rc3, wc1, wc2, wc3;
    logic [3:0]  rc4, wc4;

    mem_responder #(.READ_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_rn(addr_rn),
        .read(read), .write(write), .data_out(d1), .rd_valid(v1),
        .uninit_rd(un1), .rw_err(e1), .clr_err(clr_err), .rd_cnt(rc1), .wr_cnt(wc1)
    );
    mem_responder #(.READ_LAT(2), .CNT_W(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_rn(addr_rn),
        .read(read), .write(write), .data_out(d2), .rd_valid(v2),
        .uninit_rd(un2), .rw_err(e2), .clr_err(clr_err), .rd_cnt(rc2), .wr_cnt(wc2)
    );
    mem_responder #(.READ_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_rn(addr_rn),
        .read(read), .write(write), .data_out(d3), .rd_valid(v3),
        .uninit_rd(un3), .rw_err(e3), .clr_err(clr_err), .rd_cnt(rc3), .wr_cnt(wc3)
    );
    mem_responder #(.READ_LAT(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_rn(addr_rn),
        .read(read), .write(write), .data_out(d4), .rd_valid(v4),
        .uninit_rd(un4), .rw_err(e4), .clr_err(clr_err), .rd_cnt(rc4), .wr_cnt(wc4)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One posedge (inputs sampled), then settle at the negedge for checking
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp;
        rst_n   = 1'b0;
        data_in = '0;
        addr_rn = '0;
        read    = 1'b0;
        write   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_data_out", d1, 8'h00);
        chk("rst_rd_valid", v1, 1'b0);
        chk("rst_uninit", un1, 1'b0);
        chk("rst_rw_err", e1, 1'b0);
        chk("rst_rd_cnt", rc1, 16'd0);
        chk("rst_wr_cnt", wc1, 16'd0);
        chk("rst_l3_valid", v3, 1'b0);

        // Read of a never-written word
        read = 1'b1; addr_rn = 5'd5;
        step();
        read = 1'b0;
        chk("rd5_data", d1, 8'h00);
        chk("rd5_valid", v1, 1'b1);
        chk("rd5_uninit", un1, 1'b1);
        chk("rd5_rd_cnt", rc1, 16'd1);
        chk("rd5_wr_cnt", wc1, 16'd0);
        step();
        chk("idle_valid_low", v1, 1'b0);
        chk("idle_uninit_low", un1, 1'b0);
        chk("idle_data_hold", d1, 8'h00);

        // Write at N, read same address at N+1
        write = 1'b1; addr_rn = 5'd3; data_in = 8'h41;
        step();
        write = 1'b0; read = 1'b1;
        step();
        read = 1'b0;
        chk("raw_data", d1, 8'h41);
        chk("raw_valid", v1, 1'b1);
        chk("raw_uninit", un1, 1'b0);
        chk("raw_wr_cnt", wc1, 16'd1);
        chk("raw_rd_cnt", rc1, 16'd2);

        // Collision on addr 7 holding 8'h77
        write = 1'b1; addr_rn = 5'd7; data_in = 8'h77;
        step();
        read = 1'b1; data_in = 8'hFF;
        step();
        read = 1'b0; write = 1'b0;
        chk("col_rw_err", e1, 1'b1);
        chk("col_wr_cnt", wc1, 16'd2);
        chk("col_rd_cnt", rc1, 16'd2);
        chk("col_no_valid", v1, 1'b0);
        read = 1'b1;
        step();
        read = 1'b0;
        chk("col_mem_kept", d1, 8'h77);
        chk("col_rd_after", rc1, 16'd3);
        chk("col_err_sticky", e1, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_rw_err", e1, 1'b0);
        read = 1'b1; write = 1'b1; clr_err = 1'b1;
        step();
        read = 1'b0; write = 1'b0; clr_err = 1'b0;
        chk("col_clr_set_wins", e1, 1'b1);
        chk("col_clr_wr_cnt", wc1, 16'd2);
        chk("col_clr_rd_cnt", rc1, 16'd3);

        // Fresh reset, fill all 32 words
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_rw_err", e1, 1'b0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            write   = 1'b1;
            addr_rn = 5'(i);
            data_in = 8'(i) ^ 8'hA5;
            step();
            if (i == 14) chk("c4_wr_cnt_15", wc4, 4'hF);
            if (i == 19) begin
                chk("c4_wr_cnt_sat20", wc4, 4'hF);
                chk("l1_wr_cnt_20", wc1, 16'd20);
            end
        end
        write = 1'b0;
        chk("fill_wr_cnt", wc1, 16'd32);
        chk("fill_c4_sat", wc4, 4'hF);

        // Back-to-back reads 0..31
        for (int i = 0; i < 32; i++) begin
            read    = 1'b1;
            addr_rn = 5'(i);
            step();
            exp = 8'(i) ^ 8'hA5;
            chk("b2b_l1_data", d1, exp);
            chk("b2b_l1_valid", v1, 1'b1);
            chk("b2b_l1_uninit", un1, 1'b0);
            chk("b2b_c4_data", d4, exp);
            if (i >= 1) begin
                chk("b2b_l2_data", d2, 8'(i - 1) ^ 8'hA5);
                chk("b2b_l2_valid", v2, 1'b1);
            end else begin
                chk("b2b_l2_first_idle", v2, 1'b0);
            end
            if (i >= 2) begin
                chk("b2b_l3_data", d3, 8'(i - 2) ^ 8'hA5);
                chk("b2b_l3_valid", v3, 1'b1);
            end else begin
                chk("b2b_l3_first_idle", v3, 1'b0);
            end
        end
        read = 1'b0;
        step();
        chk("drain_l1_valid", v1, 1'b0);
        chk("drain_l2_data", d2, 8'd31 ^ 8'hA5);
        chk("drain_l3_data30", d3, 8'd30 ^ 8'hA5);
        chk("drain_l3_valid30", v3, 1'b1);
        step();
        chk("drain_l3_data31", d3, 8'd31 ^ 8'hA5);
        chk("drain_l3_valid31", v3, 1'b1);
        step();
        chk("drain_l3_done", v3, 1'b0);
        chk("drain_l3_hold", d3, 8'd31 ^ 8'hA5);
        chk("b2b_rd_cnt", rc3, 16'd32);

        // Write to an address while a READ_LAT=3 read of it is in flight
        read = 1'b1; addr_rn = 5'd4;
        step();
        read = 1'b0; write = 1'b1; data_in = 8'h3C;
        step();
        write = 1'b0;
        step();
        chk("pend_l3_old_data", d3, 8'hA1);
        chk("pend_l3_valid", v3, 1'b1);
        read = 1'b1;
        step();
        read = 1'b0;
        chk("pend_new_data", d1, 8'h3C);

        // Reset with a READ_LAT=2 read in flight
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        write = 1'b1; addr_rn = 5'd9; data_in = 8'h5A;
        step();
        write = 1'b0; read = 1'b1;
        step();
        read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("flush_l2_valid", v2, 1'b0);
        chk("flush_l2_data", d2, 8'h00);
        chk("flush_l2_rd_cnt", rc2, 16'd0);
        chk("flush_l2_wr_cnt", wc2, 16'd0);
        chk("flush_l1_data", d1, 8'h00);
        step();
        chk("flush_l2_no_pulse", v2, 1'b0);
        rst_n = 1'b1;
        step();
        read = 1'b1; addr_rn = 5'd9;
        step();
        read = 1'b0;
        chk("post_l2_not_yet", v2, 1'b0);
        step();
        chk("post_l2_data", d2, 8'h00);
        chk("post_l2_valid", v2, 1'b1);
        chk("post_l2_uninit", un2, 1'b1);
        chk("post_l2_rd_cnt", rc2, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
